// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag bit positions and arbiter state encoding
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_DIV  = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

    localparam int FLAG_N     = 31;
    localparam int FLAG_Z     = 30;
    localparam int FLAG_INV   = 29;
    localparam int FLAG_V     = 28;
    localparam int FLAG_BC_LO = 16;

    localparam logic [31:0] FLAG_MASK_DEF = 32'hF00F_0000;

    // Number of cycles the ALU inputs must be held for a given opcode
    function automatic int op_latency(alu_op_e op, int mul_lat, int div_lat);
        return op == OP_MUL ? mul_lat : op == OP_DIV ? div_lat : 1;
    endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: request, response and ALU-side signals of the issue arbiter
interface alu_issue_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [2:0]  req_op0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [2:0]  req_op1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [31:0] rsp_flags;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic [31:0] alu_flags;
    logic        busy;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
               alu_out, alu_flags,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, alu_a, alu_b, alu_op, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
               alu_out, alu_flags,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, alu_a, alu_b, alu_op, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant with pointer advanced on each accepted grant
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr;

    assign gnt    = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
    assign gnt_id = gnt[1];

    // Favour the port that was not granted last time
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (upd)
            ptr <= ~gnt_id;
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one combinational ALU between two requesters, one op in flight
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int          MUL_LAT   = 2,
    parameter int          DIV_LAT   = 4,
    parameter logic [31:0] FLAG_MASK = FLAG_MASK_DEF
) (
    input logic                 clk,
    input logic                 rst,
    alu_issue_arbiter_if.slave  bus
);

    localparam int LMAX = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW   = LMAX > 1 ? $clog2(LMAX) : 1;

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   hold_a, hold_b;
    alu_op_e       hold_op;
    logic          hold_id;
    logic          rsp_id_q;
    logic [31:0]   rsp_result_q, rsp_flags_q;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          accept;
    logic          done;
    alu_op_e       req_op;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .upd    (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // The grant doubles as req_ready, so any grant in IDLE is a handshake
    assign accept = state == IDLE && |gnt;
    assign done   = state == EXEC && cnt == '0;
    assign req_op = gnt_id ? alu_op_e'(bus.req_op1) : alu_op_e'(bus.req_op0);

    // ALU sees held operands only during EXEC, otherwise idles in pass-through of zero
    assign bus.alu_a      = state == EXEC ? hold_a : 32'd0;
    assign bus.alu_b      = state == EXEC ? hold_b : 32'd0;
    assign bus.alu_op     = state == EXEC ? hold_op : OP_PASS;
    assign bus.busy       = state != IDLE;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = gnt;
                if (|gnt)
                    state_nxt = EXEC;
            end
            EXEC: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand hold, latency countdown and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            hold_a       <= '0;
            hold_b       <= '0;
            hold_op      <= OP_PASS;
            hold_id      <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            if (accept) begin
                hold_a  <= gnt_id ? bus.req_a1 : bus.req_a0;
                hold_b  <= gnt_id ? bus.req_b1 : bus.req_b0;
                hold_op <= req_op;
                hold_id <= gnt_id;
                cnt     <= CW'(op_latency(req_op, MUL_LAT, DIV_LAT) - 1);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (done) begin
                rsp_id_q     <= hold_id;
                rsp_result_q <= bus.alu_out;
                rsp_flags_q  <= bus.alu_flags & FLAG_MASK;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed bench with a behavioural ALU and a response scoreboard
module tb_alu_issue_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [31:0] flg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   grant_log[$];

    always #5 clk = ~clk;

    alu_issue_arbiter_if bus ();

    alu_issue_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU: {flags, result}; low flag bits carry junk that must be masked off
    function automatic logic [63:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        logic [31:0] r;
        logic [31:0] f;
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = p[31:0];
            3'd5: r = (b == 0) ? 32'd0 : a / b;
            3'd6: r = ~a;
            default: r = a;
        endcase
        f           = '0;
        f[15:0]     = r[15:0];
        f[27:20]    = 8'hFF;
        f[FLAG_N]   = r[31];
        f[FLAG_Z]   = (r == 0);
        f[FLAG_INV] = (op == 3'd5) && (b == 0);
        f[FLAG_V]   = (op == 3'd4) && (|p[63:32]);
        for (int i = 0; i < 4; i++)
            f[FLAG_BC_LO + i] = a[8*i +: 8] >= b[8*i +: 8];
        return {f, r};
    endfunction

    // The shared ALU sitting outside the arbiter
    always_comb {bus.alu_flags, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.req_valid[p] && bus.req_ready[p]) begin
                    logic [63:0] e;
                    exp_t        x;
                    e = p == 0 ? alu_fn(bus.req_a0, bus.req_b0, bus.req_op0)
                               : alu_fn(bus.req_a1, bus.req_b1, bus.req_op1);
                    x.id  = p[0];
                    x.res = e[31:0];
                    x.flg = e[63:32] & FLAG_MASK_DEF;
                    sb.push_back(x);
                    grant_log.push_back(p);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sb_rsp_id", 32'(bus.rsp_id), 32'(x.id));
                    chk("sb_rsp_result", bus.rsp_result, x.res);
                    chk("sb_rsp_flags", bus.rsp_flags, x.flg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(int p, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        if (p == 0) begin
            bus.req_a0  = a;
            bus.req_b0  = b;
            bus.req_op0 = op;
        end else begin
            bus.req_a1  = a;
            bus.req_b1  = b;
            bus.req_op1 = op;
        end
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic wait_accept(int p);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready[p];
        end
        @(posedge clk);
        #1;
        bus.req_valid[p] = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) break;
        end
        chk("idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
        chk({tag, "_rsp_flags"}, bus.rsp_flags, 32'd0);
        chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
        chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
        chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'd7);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int   n;
        int   gl;
        logic seen;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0    = '0;
        bus.req_b0    = '0;
        bus.req_op0   = '0;
        bus.req_a1    = '0;
        bus.req_b1    = '0;
        bus.req_op1   = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD 5+7 on port 0
        bus.rsp_ready = 1'b1;
        drive(0, 32'd5, 32'd7, OP_ADD);
        wait_accept(0);
        chk("add_busy", 32'(bus.busy), 32'd1);
        wait_rsp(n);
        chk("add_latency", 32'(n), 32'd2);
        chk("add_result", bus.rsp_result, 32'd12);
        chk("add_flags", bus.rsp_flags, 32'h000E_0000);
        chk("add_id", 32'(bus.rsp_id), 32'd0);
        idle();

        // Fairness: both ports continuously valid from reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        drive(0, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_AND);
        drive(1, 32'h1234_5678, 32'hFFFF_0000, OP_AND);
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        chk("rr_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
        idle();

        // DIV 10/0 on port 1
        drive(1, 32'd10, 32'd0, OP_DIV);
        wait_accept(1);
        wait_rsp(n);
        chk("div0_latency", 32'(n), 32'd5);
        chk("div0_result", bus.rsp_result, 32'd0);
        chk("div0_flags", bus.rsp_flags, 32'h600F_0000);
        chk("div0_id", 32'(bus.rsp_id), 32'd1);
        idle();

        // MUL overflow on port 0
        drive(0, 32'h0001_0000, 32'h0001_0000, OP_MUL);
        wait_accept(0);
        wait_rsp(n);
        chk("mul_latency", 32'(n), 32'd3);
        chk("mul_result", bus.rsp_result, 32'd0);
        chk("mul_flags", bus.rsp_flags, 32'h500F_0000);
        chk("mul_id", 32'(bus.rsp_id), 32'd0);
        idle();

        // Back-pressure: response held while consumer stalls
        bus.rsp_ready = 1'b0;
        drive(0, 32'd100, 32'd1, OP_SUB);
        wait_accept(0);
        wait_rsp(n);
        chk("bp_latency", 32'(n), 32'd2);
        gl = grant_log.size();
        @(posedge clk);
        #1;
        drive(1, 32'h0000_00A0, 32'h0000_000B, OP_OR);
        repeat (3) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result", bus.rsp_result, 32'd99);
            chk("bp_rsp_flags", bus.rsp_flags, 32'h000F_0000);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
        end
        chk("bp_no_early_accept", 32'(grant_log.size()), 32'(gl));
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_accept(1);
        wait_rsp(n);
        chk("bp_next_latency", 32'(n), 32'd2);
        chk("bp_next_result", bus.rsp_result, 32'h0000_00AB);
        chk("bp_next_id", 32'(bus.rsp_id), 32'd1);
        idle();

        // Asynchronous reset in the middle of a divide
        drive(1, 32'd10, 32'd3, OP_DIV);
        wait_accept(1);
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd1);
        chk("rst_mid_alu_op", 32'(bus.alu_op), 32'd5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 32'd3, 32'd4, OP_ADD);
        wait_accept(0);
        wait_rsp(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        chk("post_rst_result", bus.rsp_result, 32'd7);
        chk("post_rst_flags", bus.rsp_flags, 32'h000E_0000);
        chk("post_rst_id", 32'(bus.rsp_id), 32'd0);
        idle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
